// File: rtl/ex_maddsub_seq_if.sv
// Interface bundle for the EX-stage multiply-accumulate/subtract sequencer.
// The master modport is the pipeline side; the slave modport is ex_maddsub_seq.
interface ex_maddsub_seq_if;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [5:0]  stall;
    logic        stallreq_o;
    logic [63:0] hilo_o;
    logic        we_hilo_o;
    logic        busy_o;

    modport master (
        output aluop_i, reg1_i, reg2_i, hi_i, lo_i, stall,
        input  stallreq_o, hilo_o, we_hilo_o, busy_o
    );

    modport slave (
        input  aluop_i, reg1_i, reg2_i, hi_i, lo_i, stall,
        output stallreq_o, hilo_o, we_hilo_o, busy_o
    );
endinterface

// File: rtl/ex_maddsub_seq.sv
// Two-cycle MADD/MADDU (and MSUB/MSUBU when MSUB_EN is defined) sequencer for the EX stage:
// cycle 1 multiplies into hilo_temp, cycle 2 adds the forwarded HI/LO and writes it.
module ex_maddsub_seq (
    input logic            Clk,
    input logic            Rst,
    ex_maddsub_seq_if.slave bus
);
    localparam logic [7:0] ExeMaddOp  = 8'b1010_0110;
    localparam logic [7:0] ExeMadduOp = 8'b1010_1000;
    localparam logic [7:0] ExeMsubOp  = 8'b1010_1010;
    localparam logic [7:0] ExeMsubuOp = 8'b1010_1011;

    typedef enum logic {StIdle, StAcc} state_e;

    state_e      state_q, state_d;
    logic [63:0] hilo_temp_q, hilo_temp_d;

    logic        is_madd;
    logic        is_signed;
    logic [63:0] op_a, op_b;
    logic [63:0] product;
    logic [63:0] prod_acc;
    logic        advance;

    logic        stallreq;
    logic        we_hilo;
    logic [63:0] hilo;

    // Only the EX stall bit matters here.
    logic unused_stall;
    assign unused_stall = ^{bus.stall[5], bus.stall[3:0]};
    assign advance      = ~bus.stall[4];

`ifdef MSUB_EN
    logic is_sub;

    always_comb begin
        is_madd   = 1'b0;
        is_signed = 1'b0;
        is_sub    = 1'b0;
        case (bus.aluop_i)
            ExeMaddOp:  begin is_madd = 1'b1; is_signed = 1'b1; end
            ExeMadduOp: begin is_madd = 1'b1; end
            ExeMsubOp:  begin is_madd = 1'b1; is_signed = 1'b1; is_sub = 1'b1; end
            ExeMsubuOp: begin is_madd = 1'b1; is_sub = 1'b1; end
            default: ;
        endcase
    end
`else
    // MSUB/MSUBU opcodes fall into the default arm and are treated as unrelated ops.
    logic [15:0] unused_sub_ops;
    assign unused_sub_ops = {ExeMsubOp, ExeMsubuOp};

    always_comb begin
        is_madd   = 1'b0;
        is_signed = 1'b0;
        case (bus.aluop_i)
            ExeMaddOp:  begin is_madd = 1'b1; is_signed = 1'b1; end
            ExeMadduOp: begin is_madd = 1'b1; end
            default: ;
        endcase
    end
`endif

    // Extending to 64 bits first makes the truncated product correct for both signednesses.
    assign op_a    = is_signed ? {{32{bus.reg1_i[31]}}, bus.reg1_i} : {32'b0, bus.reg1_i};
    assign op_b    = is_signed ? {{32{bus.reg2_i[31]}}, bus.reg2_i} : {32'b0, bus.reg2_i};
    assign product = op_a * op_b;

`ifdef MSUB_EN
    assign prod_acc = is_sub ? (~product + 64'd1) : product;
`else
    assign prod_acc = product;
`endif

    always_comb begin
        state_d     = state_q;
        hilo_temp_d = hilo_temp_q;
        stallreq    = 1'b0;
        we_hilo     = 1'b0;
        hilo        = 64'b0;
        case (state_q)
            StIdle: begin
                if (is_madd) begin
                    stallreq = 1'b1;
                    if (advance) begin
                        state_d     = StAcc;
                        hilo_temp_d = prod_acc;
                    end
                end
            end
            StAcc: begin
                if (is_madd) begin
                    we_hilo = 1'b1;
                    hilo    = {bus.hi_i, bus.lo_i} + hilo_temp_q;
                end
                // Either completion or a flushed slot returns to IDLE with a clean accumulator.
                if (advance) begin
                    state_d     = StIdle;
                    hilo_temp_d = 64'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                hilo_temp_d = 64'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= StIdle;
            hilo_temp_q <= 64'b0;
        end else begin
            state_q     <= state_d;
            hilo_temp_q <= hilo_temp_d;
        end
    end

    // Reset must silence the outputs even while a madd op sits on aluop_i.
    assign bus.stallreq_o = stallreq & ~Rst;
    assign bus.we_hilo_o  = we_hilo & ~Rst;
    assign bus.hilo_o     = Rst ? 64'b0 : hilo;
    assign bus.busy_o     = (state_q == StAcc);
endmodule

// File: tb/tb_ex_maddsub_seq.sv
// Randomized self-checking bench for ex_maddsub_seq against a per-instruction arithmetic model.
// Honours MSUB_EN the same way the design does.
module tb_ex_maddsub_seq;
    localparam logic [7:0] ExeMaddOp  = 8'b1010_0110;
    localparam logic [7:0] ExeMadduOp = 8'b1010_1000;
    localparam logic [7:0] ExeMsubOp  = 8'b1010_1010;
    localparam logic [7:0] ExeMsubuOp = 8'b1010_1011;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    ex_maddsub_seq_if bus ();

    ex_maddsub_seq dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    int n_checks   = 0;
    int n_fails    = 0;
    int wr_seen    = 0;
    int exp_writes = 0;

    // A HI/LO write is committed on each edge where we_hilo is high and EX is not stalled.
    always @(negedge Clk) begin
        if (!Rst && bus.we_hilo_o && !bus.stall[4]) wr_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_madd(input logic [7:0] op);
`ifdef MSUB_EN
        return (op == ExeMaddOp) || (op == ExeMadduOp) || (op == ExeMsubOp) || (op == ExeMsubuOp);
`else
        return (op == ExeMaddOp) || (op == ExeMadduOp);
`endif
    endfunction

    // {HI,LO} +/- reg1*reg2, everything modulo 2^64.
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint p;
        if (op == ExeMaddOp || op == ExeMsubOp) p = longint'(int'(a)) * longint'(int'(b));
        else p = longint'({32'b0, a}) * longint'({32'b0, b});
        if (op == ExeMsubOp || op == ExeMsubuOp) p = -p;
        return hl + 64'(p);
    endfunction

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [5:0] stall_vec(input bit s4);
        logic [5:0] v;
        v = 6'($urandom);
        v[4] = s4;
        return v;
    endfunction

    task automatic do_op(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input int idle_st, input int acc_st);
        logic [63:0] exp;
        bus.aluop_i = op;
        bus.reg1_i  = r1;
        bus.reg2_i  = r2;
        // Garbage HI/LO during the first cycle: only the ACC-cycle values may matter.
        bus.hi_i    = $urandom;
        bus.lo_i    = $urandom;
        if (!is_madd(op)) begin
            bus.stall = stall_vec($urandom_range(0, 1) == 1);
            @(negedge Clk);
            check("other_stallreq", 64'(bus.stallreq_o), 64'd0);
            check("other_we", 64'(bus.we_hilo_o), 64'd0);
            check("other_hilo", bus.hilo_o, 64'd0);
            check("other_busy", 64'(bus.busy_o), 64'd0);
            next_cycle();
            return;
        end
        for (int i = 0; i <= idle_st; i++) begin
            bus.stall = stall_vec(i < idle_st);
            @(negedge Clk);
            check("idle_stallreq", 64'(bus.stallreq_o), 64'd1);
            check("idle_we", 64'(bus.we_hilo_o), 64'd0);
            check("idle_hilo", bus.hilo_o, 64'd0);
            check("idle_busy", 64'(bus.busy_o), 64'd0);
            next_cycle();
        end
        bus.hi_i = hi;
        bus.lo_i = lo;
        exp = model(op, r1, r2, {hi, lo});
        for (int i = 0; i <= acc_st; i++) begin
            bus.stall = stall_vec(i < acc_st);
            @(negedge Clk);
            check("acc_stallreq", 64'(bus.stallreq_o), 64'd0);
            check("acc_we", 64'(bus.we_hilo_o), 64'd1);
            check("acc_hilo", bus.hilo_o, exp);
            check("acc_busy", 64'(bus.busy_o), 64'd1);
            next_cycle();
        end
        exp_writes++;
    endtask

    initial begin
        int w0;
        logic [7:0] ops [4];
        ops[0] = ExeMaddOp;
        ops[1] = ExeMadduOp;
        ops[2] = ExeMsubOp;
        ops[3] = ExeMsubuOp;

        // Reset with a madd op already present: outputs must stay quiet.
        bus.aluop_i = ExeMaddOp;
        bus.reg1_i  = 32'd2;
        bus.reg2_i  = 32'd3;
        bus.hi_i    = 32'd0;
        bus.lo_i    = 32'd0;
        bus.stall   = 6'b0;
        #2;
        check("rst_stallreq", 64'(bus.stallreq_o), 64'd0);
        check("rst_we", 64'(bus.we_hilo_o), 64'd0);
        check("rst_hilo", bus.hilo_o, 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        next_cycle();
        next_cycle();
        Rst = 1'b0;

        // Basic MADD, then sign handling of MADD vs MADDU.
        do_op(ExeMaddOp, 32'd2, 32'd3, 32'd0, 32'd10, 0, 0);
        check("madd_basic_const", model(ExeMaddOp, 32'd2, 32'd3, 64'd10), 64'h10);
        do_op(ExeMaddOp, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0, 0, 0);
        do_op(ExeMadduOp, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0, 0, 0);
        do_op(ExeMsubuOp, 32'd1, 32'd1, 32'd0, 32'd0, 0, 0);
        do_op(ExeMsubOp, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd1, 0, 0);

        // Held stall in ACC, then stall in the IDLE cycle.
        do_op(ExeMaddOp, 32'd7, 32'd6, 32'd1, 32'd2, 0, 3);
        do_op(ExeMaddOp, 32'd9, 32'hFFFF_FFF0, 32'h10, 32'h20, 2, 1);

        // Back-to-back madds with forwarded HI/LO.
        w0 = wr_seen;
        do_op(ExeMaddOp, 32'd1, 32'd1, 32'd0, 32'd0, 0, 0);
        do_op(ExeMaddOp, 32'd2, 32'd2, 32'd0, 32'd1, 0, 0);
        check("b2b_writes", 64'(wr_seen - w0), 64'd2);

        // Flushed slot in ACC: no write, back to IDLE on the next edge.
        bus.aluop_i = ExeMaddOp;
        bus.reg1_i  = 32'd5;
        bus.reg2_i  = 32'd5;
        bus.stall   = 6'b0;
        next_cycle();
        bus.aluop_i = 8'h00;
        @(negedge Clk);
        check("flush_we", 64'(bus.we_hilo_o), 64'd0);
        check("flush_hilo", bus.hilo_o, 64'd0);
        check("flush_stallreq", 64'(bus.stallreq_o), 64'd0);
        check("flush_busy", 64'(bus.busy_o), 64'd1);
        next_cycle();
        @(negedge Clk);
        check("flush_idle_busy", 64'(bus.busy_o), 64'd0);
        next_cycle();
        do_op(ExeMaddOp, 32'd3, 32'd3, 32'd0, 32'd0, 0, 0);

        // Asynchronous reset in the middle of an ACC cycle.
        bus.aluop_i = ExeMaddOp;
        bus.reg1_i  = 32'd7;
        bus.reg2_i  = 32'd9;
        bus.stall   = 6'b0;
        next_cycle();
        #2;
        check("pre_rst_busy", 64'(bus.busy_o), 64'd1);
        Rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_stallreq", 64'(bus.stallreq_o), 64'd0);
        check("arst_we", 64'(bus.we_hilo_o), 64'd0);
        check("arst_hilo", bus.hilo_o, 64'd0);
        next_cycle();
        Rst = 1'b0;
        do_op(ExeMaddOp, 32'd4, 32'd4, 32'd0, 32'd0, 0, 0);

        // Random mix of madd-family and unrelated opcodes.
        for (int n = 0; n < 200; n++) begin
            logic [7:0] op;
            op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 3)];
            do_op(op, $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        check("write_count", 64'(wr_seen), 64'(exp_writes));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/ex_maddsub_seq.md
EX_MADDSUB_SEQ -- requirements
Module: ex_maddsub_seq

Interface
REQ-001 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 Rst  input  1  asynchronous, active-high reset.
REQ-003 aluop_i  input  8  EX-stage ALU opcode (`AluOpBus`); acted on: EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP.
REQ-004 reg1_i, reg2_i  input  32 each  multiplicand and multiplier.
REQ-005 hi_i, lo_i  input  32 each  current HI/LO, already forwarded from MEM/WB.
REQ-006 stall  input  6  pipeline stall vector from ctrl; 1 = STOP.
REQ-007 stallreq_o  output  1  EX stall request to ctrl; combinational.
REQ-008 hilo_o  output  64  accumulated result, {HI,LO}; combinational.
REQ-009 we_hilo_o  output  1  HI/LO write enable for the EX/MEM register; combinational.
REQ-010 busy_o  output  1  high while state = ACC.

Function
REQ-011 The block SHALL have two states: IDLE and ACC; there are no other states.
REQ-012 A madd-class op SHALL be one of the four opcodes in REQ-003, subject to REQ-028.
REQ-013 A state advance SHALL occur only on an edge where stall[4] = 0; when stall[4] = 1, the state and hilo_temp SHALL both hold.
REQ-014 IDLE with a madd-class op: stallreq_o = 1, we_hilo_o = 0, hilo_o = 0; on advance, hilo_temp <= signed product (MADD/MSUB) or unsigned product (MADDU/MSUBU) of reg1_i*reg2_i, 64-bit.
REQ-015 For MSUB/MSUBU, the stored hilo_temp SHALL be the 64-bit two's complement negation of the product (~p + 1); for an unsigned op, the negation applies after the unsigned multiply.
REQ-016 IDLE to ACC SHALL occur on the advance edge of REQ-014.
REQ-017 ACC with a madd-class op: stallreq_o = 0, we_hilo_o = 1, hilo_o = {hi_i,lo_i} + hilo_temp, modulo 2^64 with carry-out discarded; on advance, go to IDLE.
REQ-018 ACC with a non-madd-class op (e.g. a flushed slot): we_hilo_o = 0, stallreq_o = 0, hilo_o = 0; on the next edge, go to IDLE and clear hilo_temp.
REQ-019 IDLE with a non-madd-class op: stallreq_o = 0, we_hilo_o = 0, hilo_o = 0; stay in IDLE.
REQ-020 Latency: one madd-class instruction SHALL occupy EX for exactly 2 cycles when stall[4] = 0, and write HI/LO exactly once.
REQ-021 Back-to-back madd-class instructions SHALL each pass through IDLE, then ACC, independently; the ACC-to-IDLE edge SHALL NOT start the next operation.
REQ-022 hi_i/lo_i SHALL be sampled in the ACC cycle, not the IDLE cycle, so forwarding from a preceding HI/LO write is honoured.

Reset
REQ-023 Rst = 1 SHALL immediately force state = IDLE and hilo_temp = 0, independent of Clk.
REQ-024 During reset: stallreq_o = 0, we_hilo_o = 0, hilo_o = 0, busy_o = 0.
REQ-025 Reset in ACC SHALL abort the operation with no HI/LO write issued.
REQ-026 After reset deasserts, the first edge SHALL behave as IDLE.

Configuration
REQ-027 The macro MSUB_EN SHALL control MSUB/MSUBU support.
REQ-028 MSUB_EN defined: all four opcodes are madd-class. Not defined: EXE_MSUB_OP/EXE_MSUBU_OP are not madd-class (no stall, no write); the negation logic SHALL be absent.

Verification
REQ-029 Reset, then MADD with reg1 = 2, reg2 = 3, HI:LO = 0:10 -> cycle 1: stallreq = 1; cycle 2: we_hilo = 1, hilo_o = 0x0000_0000_0000_0010.
REQ-030 MADD with reg1 = 0xFFFFFFFF (-1), reg2 = 5, HI:LO = 0:0 -> hilo_o = 0xFFFF_FFFF_FFFF_FFFB; MADDU with the same operands -> 0x0000_0004_FFFF_FFFB.
REQ-031 MSUBU with reg1 = 1, reg2 = 1, HI:LO = 0:0 -> hilo_o = 0xFFFF_FFFF_FFFF_FFFF (MSUB_EN defined); no stallreq and no write (MSUB_EN undefined).
REQ-032 MADD with stall[4] = 1 held for 3 cycles in ACC -> busy_o stays 1 and we_hilo_o stays 1; one transition to IDLE after stall[4] falls.
REQ-033 Rst asserted mid-cycle while in ACC -> busy_o, stallreq_o and we_hilo_o drop to 0 without a Clk edge; the next MADD result is unaffected by the aborted hilo_temp.
REQ-034 Two consecutive MADDs (1*1 then 2*2, HI:LO forwarded as 0:0 then 0:1) -> exactly two writes, with values 0x1 then 0x5, over 4 cycles.
